// File: rtl/lut_ram_arbiter_pkg.sv
// rtl/lut_ram_arbiter_pkg.sv - shared types and constants for the lut_ram front end
package lut_ram_arbiter_pkg;

    typedef enum logic {ST_INIT, ST_RUN} arb_state_t;

    localparam int NUM_PORTS = 2;

endpackage

// File: rtl/lut_ram_arbiter_rr.sv
// rtl/lut_ram_arbiter_rr.sv - stateless two-requester round-robin grant
module rr_arbiter_2
    import lut_ram_arbiter_pkg::*;
(
    input  logic                 en,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic                 prio,
    output logic [NUM_PORTS-1:0] grant
);

    always_comb begin
        grant = '0;
        if (en) begin
            if (&req_valid) begin
                grant = prio ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end
    end

endmodule

// File: rtl/lut_ram_arbiter.sv
// rtl/lut_ram_arbiter.sv - clears an external lut_ram after reset, then shares it between two ports
module lut_ram_arbiter
    import lut_ram_arbiter_pkg::*;
#(
    parameter int LUT_WIDTH      = 32,
    parameter int LUT_DEPTH      = 256,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW            = $clog2(LUT_DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                req_valid,
    output logic [NUM_PORTS-1:0]                req_ready,
    input  logic [NUM_PORTS-1:0]                req_we,
    input  logic [NUM_PORTS-1:0][AW-1:0]        req_addr,
    input  logic [NUM_PORTS-1:0][LUT_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]                rsp_valid,
    output logic [LUT_WIDTH-1:0]                rsp_rdata,
    output logic                                init_done,
    output logic                                ram_wr_en,
    output logic [AW-1:0]                       ram_wr_addr,
    output logic [LUT_WIDTH-1:0]                ram_wr_data,
    output logic [AW-1:0]                       ram_rd_addr,
    input  logic [LUT_WIDTH-1:0]                ram_rd_data
);

    arb_state_t           state;
    logic [AW-1:0]        init_cnt;
    logic                 prio;
    logic [NUM_PORTS-1:0] grant;
    logic                 sel;
    logic                 accept;
    logic                 run;

    assign run       = (state == ST_RUN);
    assign init_done = run;
    assign sel       = grant[1];
    assign accept    = |grant;
    assign req_ready = grant;

    rr_arbiter_2 u_arb (
        .en        (run),
        .req_valid (req_valid),
        .prio      (prio),
        .grant     (grant)
    );

    // Only one op reaches the RAM per cycle; unused ports are parked at zero.
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_rd_addr = '0;
        if (!run) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = init_cnt;
        end else if (accept) begin
            if (req_we[sel]) begin
                ram_wr_en   = 1'b1;
                ram_wr_addr = req_addr[sel];
                ram_wr_data = req_wdata[sel];
            end else begin
                ram_rd_addr = req_addr[sel];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_cnt  <= '0;
            prio      <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            if (!run) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == AW'(LUT_DEPTH - 1)) begin
                    state <= ST_RUN;
                end
            end
            if (accept) begin
                prio <= ~sel;
                if (!req_we[sel]) begin
                    rsp_valid <= grant;
                    rsp_rdata <= ram_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_ram_arbiter.sv
// tb/tb_lut_ram_arbiter.sv - scoreboard bench for lut_ram_arbiter with an attached RAM model
module tb_lut_ram_arbiter;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam logic [W-1:0] SEED = 32'hA5A5_A5A5;

    typedef struct {
        int           port;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int errors   = 0;
    bit mon_en   = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];

    logic                 a_rst, b_rst;
    logic [1:0]           a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [1:0][AW-1:0]   a_req_addr;
    logic [1:0][W-1:0]    a_req_wdata;
    logic [W-1:0]         a_rsp_rdata, a_ram_wr_data, a_ram_rd_data;
    logic                 a_init_done, a_ram_wr_en;
    logic [AW-1:0]        a_ram_wr_addr, a_ram_rd_addr;
    logic [1:0]           b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [1:0][AW-1:0]   b_req_addr;
    logic [1:0][W-1:0]    b_req_wdata;
    logic [W-1:0]         b_rsp_rdata, b_ram_wr_data, b_ram_rd_data;
    logic                 b_init_done, b_ram_wr_en;
    logic [AW-1:0]        b_ram_wr_addr, b_ram_rd_addr;

    logic [W-1:0] mem_a [D];
    logic [W-1:0] mem_b [D];
    bit seeded_a = 1'b0;
    bit seeded_b = 1'b0;

    // RAM models start with a non-zero pattern so the clear is observable.
    always @(posedge clk) begin
        if (!seeded_a) begin
            for (int i = 0; i < D; i++) mem_a[i] <= SEED;
            seeded_a <= 1'b1;
        end else if (a_ram_wr_en) begin
            mem_a[a_ram_wr_addr] <= a_ram_wr_data;
        end
        if (!seeded_b) begin
            for (int i = 0; i < D; i++) mem_b[i] <= SEED;
            seeded_b <= 1'b1;
        end else if (b_ram_wr_en) begin
            mem_b[b_ram_wr_addr] <= b_ram_wr_data;
        end
    end
    assign a_ram_rd_data = mem_a[a_ram_rd_addr];
    assign b_ram_rd_data = mem_b[b_ram_rd_addr];

    lut_ram_arbiter #(.LUT_WIDTH(W), .LUT_DEPTH(D), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .init_done(a_init_done),
        .ram_wr_en(a_ram_wr_en), .ram_wr_addr(a_ram_wr_addr), .ram_wr_data(a_ram_wr_data),
        .ram_rd_addr(a_ram_rd_addr), .ram_rd_data(a_ram_rd_data)
    );

    lut_ram_arbiter #(.LUT_WIDTH(W), .LUT_DEPTH(D), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .init_done(b_init_done),
        .ram_wr_en(b_ram_wr_en), .ram_wr_addr(b_ram_wr_addr), .ram_wr_data(b_ram_wr_data),
        .ram_rd_addr(b_ram_rd_addr), .ram_rd_data(b_ram_rd_data)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic [1:0] v, input logic [1:0] we,
                           input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                           input logic [W-1:0] wd0, input logic [W-1:0] wd1);
        a_req_valid    = v;
        a_req_we       = we;
        a_req_addr[0]  = ad0;
        a_req_addr[1]  = ad1;
        a_req_wdata[0] = wd0;
        a_req_wdata[1] = wd1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int port, input logic [W-1:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        q_a.push_back(e);
    endtask

    // Monitor: every response strobe must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (a_rsp_valid !== 2'b00) begin
                    if (q_a.size() == 0) begin
                        chk("a_unexpected_rsp", {30'd0, a_rsp_valid}, 32'd0);
                    end else begin
                        e = q_a.pop_front();
                        chk("a_rsp_valid", {30'd0, a_rsp_valid}, e.port ? 32'd2 : 32'd1);
                        chk("a_rsp_rdata", a_rsp_rdata, e.data);
                    end
                end
                if (b_rsp_valid !== 2'b00) begin
                    if (q_b.size() == 0) begin
                        chk("b_unexpected_rsp", {30'd0, b_rsp_valid}, 32'd0);
                    end else begin
                        e = q_b.pop_front();
                        chk("b_rsp_valid", {30'd0, b_rsp_valid}, e.port ? 32'd2 : 32'd1);
                        chk("b_rsp_rdata", b_rsp_rdata, e.data);
                    end
                end
            end
        end
    end

    // No-clear instance: usable the cycle after reset, RAM contents untouched.
    initial begin
        exp_t e;
        b_rst = 1'b1;
        b_req_valid = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        b_rst = 1'b0;
        b_req_valid = 2'b10;
        b_req_addr[1] = 3'd4;
        @(negedge clk);
        chk("b_init_done", {31'd0, b_init_done}, 32'd1);
        chk("b_ready", {30'd0, b_req_ready}, 32'd2);
        chk("b_wr_en", {31'd0, b_ram_wr_en}, 32'd0);
        chk("b_rd_addr", {29'd0, b_ram_rd_addr}, 32'd4);
        e.port = 1;
        e.data = SEED;
        q_b.push_back(e);
        next();
        b_req_valid = 2'b00;
    end

    initial begin
        a_rst = 1'b1;
        set_req(2'b00, 2'b00, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        a_rst  = 1'b0;
        mon_en = 1'b1;
        // Read held during clear must survive until RUN.
        set_req(2'b01, 2'b00, 3, 0, 0, 0);
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("rst_rsp_valid", {30'd0, a_rsp_valid}, 32'd0);
                chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
            end
            chk("clr_wr_en", {31'd0, a_ram_wr_en}, 32'd1);
            chk("clr_wr_addr", {29'd0, a_ram_wr_addr}, i);
            chk("clr_wr_data", a_ram_wr_data, 32'd0);
            chk("clr_ready", {30'd0, a_req_ready}, 32'd0);
            chk("clr_init_done", {31'd0, a_init_done}, 32'd0);
            next();
        end
        @(negedge clk);
        chk("run_init_done", {31'd0, a_init_done}, 32'd1);
        chk("pending_ready", {30'd0, a_req_ready}, 32'd1);
        chk("pending_wr_en", {31'd0, a_ram_wr_en}, 32'd0);
        chk("pending_rd_addr", {29'd0, a_ram_rd_addr}, 32'd3);
        push_a(0, 32'd0);
        next();

        set_req(2'b01, 2'b01, 5, 0, 32'hDEADBEEF, 0);
        @(negedge clk);
        chk("w0_ready", {30'd0, a_req_ready}, 32'd1);
        chk("w0_wr_en", {31'd0, a_ram_wr_en}, 32'd1);
        chk("w0_wr_addr", {29'd0, a_ram_wr_addr}, 32'd5);
        chk("w0_wr_data", a_ram_wr_data, 32'hDEADBEEF);
        next();

        set_req(2'b01, 2'b00, 5, 0, 0, 0);
        @(negedge clk);
        chk("r0_ready", {30'd0, a_req_ready}, 32'd1);
        chk("r0_wr_en", {31'd0, a_ram_wr_en}, 32'd0);
        push_a(0, 32'hDEADBEEF);
        next();

        set_req(2'b10, 2'b10, 0, 1, 0, 32'h11111111);
        @(negedge clk);
        chk("w1_ready", {30'd0, a_req_ready}, 32'd2);
        chk("w1_wr_addr", {29'd0, a_ram_wr_addr}, 32'd1);
        next();

        // prio is 0 after the port-1 grant, so port 0 wins the collision.
        set_req(2'b11, 2'b11, 2, 6, 32'h22222222, 32'h33333333);
        @(negedge clk);
        chk("ww_ready0", {30'd0, a_req_ready}, 32'd1);
        chk("ww_wr_data0", a_ram_wr_data, 32'h22222222);
        next();
        set_req(2'b10, 2'b11, 2, 6, 32'h22222222, 32'h33333333);
        @(negedge clk);
        chk("ww_ready1", {30'd0, a_req_ready}, 32'd2);
        chk("ww_wr_addr1", {29'd0, a_ram_wr_addr}, 32'd6);
        next();

        set_req(2'b11, 2'b00, 1, 2, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_ready", {30'd0, a_req_ready}, (k % 2) ? 32'd2 : 32'd1);
            chk("alt_rd_addr", {29'd0, a_ram_rd_addr}, (k % 2) ? 32'd2 : 32'd1);
            push_a(k % 2, (k % 2) ? 32'h22222222 : 32'h11111111);
            next();
        end

        set_req(2'b10, 2'b00, 0, 6, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("p1_only_ready", {30'd0, a_req_ready}, 32'd2);
            push_a(1, 32'h33333333);
            next();
        end
        set_req(2'b11, 2'b00, 5, 6, 0, 0);
        @(negedge clk);
        chk("after_p1_ready", {30'd0, a_req_ready}, 32'd1);
        push_a(0, 32'hDEADBEEF);
        next();
        @(negedge clk);
        chk("after_p1_ready2", {30'd0, a_req_ready}, 32'd2);
        push_a(1, 32'h33333333);
        next();

        set_req(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle_wr_en", {31'd0, a_ram_wr_en}, 32'd0);
        chk("idle_rd_addr", {29'd0, a_ram_rd_addr}, 32'd0);
        chk("idle_wr_addr", {29'd0, a_ram_wr_addr}, 32'd0);
        chk("idle_wr_data", a_ram_wr_data, 32'd0);
        chk("idle_ready", {30'd0, a_req_ready}, 32'd0);
        next();

        // Read accepted in the reset cycle: its response must be dropped.
        set_req(2'b01, 2'b00, 5, 0, 0, 0);
        a_rst = 1'b1;
        next();
        a_rst = 1'b0;
        set_req(2'b00, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("drop_rsp_valid", {30'd0, a_rsp_valid}, 32'd0);
                chk("drop_rsp_rdata", a_rsp_rdata, 32'd0);
            end
            chk("pre_wr_addr", {29'd0, a_ram_wr_addr}, i);
            next();
        end
        a_rst = 1'b1;
        next();
        a_rst = 1'b0;
        set_req(2'b01, 2'b00, 5, 0, 0, 0);
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk("reclr_wr_en", {31'd0, a_ram_wr_en}, 32'd1);
            chk("reclr_wr_addr", {29'd0, a_ram_wr_addr}, i);
            chk("reclr_ready", {30'd0, a_req_ready}, 32'd0);
            next();
        end
        @(negedge clk);
        chk("reclr_init_done", {31'd0, a_init_done}, 32'd1);
        chk("reclr_ready_run", {30'd0, a_req_ready}, 32'd1);
        push_a(0, 32'd0);
        next();
        set_req(2'b00, 2'b00, 0, 0, 0, 0);

        for (int t = 0; t < 10 && (q_a.size() != 0 || q_b.size() != 0); t++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        chk("drain_a", q_a.size(), 32'd0);
        chk("drain_b", q_b.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule

// File: doc/lut_ram_arbiter.md
# lut_ram_arbiter

Two-port front end for a single `lut_ram` instance: clears the RAM after reset, then shares its one write port and one read port between two requesters using a valid/ready handshake and round-robin arbitration. One request is accepted per cycle. Read data returns registered one cycle after acceptance. The RAM sits outside this block; this block drives its ports.

## Interface
- `LUT_WIDTH`, 32, data width; must match the attached RAM.
- `LUT_DEPTH`, 256, entry count; power of two, ≥2; `AW = $clog2(LUT_DEPTH)`.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill all entries after reset; 0 = go straight to RUN.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in [1:0]: per-port request valid.
- `req_ready` out [1:0]: per-port accept; a transfer happens when valid && ready.
- `req_we` in [1:0]: 1 = write, 0 = read.
- `req_addr` in [1:0][AW-1:0]: per-port address.
- `req_wdata` in [1:0][LUT_WIDTH-1:0]: per-port write data.
- `rsp_valid` out [1:0]: per-port read response strobe, one cycle wide.
- `rsp_rdata` out [LUT_WIDTH-1:0]: read data, shared; qualified by `rsp_valid`.
- `init_done` out 1: high in RUN.
- `ram_wr_en` out 1, `ram_wr_addr` out AW, `ram_wr_data` out LUT_WIDTH, `ram_rd_addr` out AW: drive the RAM.
- `ram_rd_data` in LUT_WIDTH: asynchronous RAM read data.

## Operation
- States: INIT, RUN. Reset → INIT if `CLEAR_ON_RESET` = 1, otherwise RUN.
- INIT:
  - `ram_wr_en`=1, `ram_wr_addr`=`init_cnt`, `ram_wr_data`=0; `init_cnt` increments each cycle.
  - When `init_cnt` = LUT_DEPTH-1, the write completes and the state moves to RUN next cycle.
  - `req_ready`=0 throughout. Requests held valid stay pending; none are lost.
- RUN, arbitration:
  - Only one port valid → that port is granted.
  - Both ports valid → the port selected by `prio` is granted.
  - `req_ready[g]` = 1 only for the granted port `g`. Ready may depend combinationally on valid.
  - After each accepted transfer on port `g`, `prio` ← the other port. `prio` is unchanged on idle cycles. `prio` resets to 0.
- RUN, accepted write: `ram_wr_en`=1, `ram_wr_addr`/`ram_wr_data` taken from the granted port in the same cycle. No response is generated.
- RUN, accepted read: `ram_rd_addr` = granted address. `ram_rd_data` is captured into `rsp_rdata` at the edge, and `rsp_valid[g]`=1 for the following cycle only.
- Idle in RUN: `ram_wr_en`=0; `ram_rd_addr`, `ram_wr_addr`, `ram_wr_data` = 0.
- There is no response backpressure. A requester must sink `rsp_valid` whenever it is asserted.
- Reset mid-INIT restarts the clear from address 0. Reset mid-RUN drops any response pending for the next cycle.

## Timing
- Reset values, visible the cycle after the `rst` edge:
  - `rsp_valid`=0, `rsp_rdata`=0, `prio`=0, `init_cnt`=0.
  - `init_done`=0 and `req_ready`=0 when `CLEAR_ON_RESET`=1; otherwise `init_done`=1.
- Clear duration: exactly LUT_DEPTH cycles of `ram_wr_en` after reset deassertion. First request accepted in cycle LUT_DEPTH.
- Read latency: accept in cycle N → `rsp_valid`/`rsp_rdata` in cycle N+1.
- Write latency: accept in cycle N → RAM updated at end of N. A read of the same address accepted in N+1 returns the new data in N+2.
- Throughput: one transfer per cycle. With both ports continuously valid, grants alternate 0,1,0,1…
- Read and write are never issued in the same cycle; the arbiter grants only one op.

## Structure
- Package `lut_ram_arbiter_pkg`:
  - `typedef enum logic {ST_INIT, ST_RUN} arb_state_t`
  - `NUM_PORTS = 2`
- Sub-module `rr_arbiter_2`: combinational grant from `req_valid`, `prio`, and enable. Outputs a one-hot grant; holds no state.
- Top module holds the FSM, `init_cnt`, the `prio` register, the response register, and the RAM port muxing.

## Test plan
- Reset with LUT_DEPTH=8, CLEAR_ON_RESET=1 → `ram_wr_en` high 8 cycles on addr 0..7 with data 0. `init_done` rises in cycle 8. `req_ready`=0 until then.
- Port 0 writes 0xDEADBEEF @0x05, then reads 0x05 next cycle → `rsp_valid[0]` pulses once with 0xDEADBEEF. `rsp_valid[1]` stays 0.
- Both ports hold reads (@0x01, @0x02) for 4 cycles after init → grants 0,1,0,1. `rsp_valid` alternates [0],[1],[0],[1], each one cycle later.
- Port 1 alone valid 3 cycles, then both valid → port 0 granted first (`prio`=0 after port-1 grant), then port 1.
- Reset asserted at clear cycle 3 → clear restarts at addr 0 and completes 8 cycles after deassertion. A pending read response is dropped (`rsp_valid`=0).
- CLEAR_ON_RESET=0 → `init_done`=1 the cycle after reset. A read of a never-written address is accepted with no clear cycles.
